// File: rtl/ex_div_sequencer_pkg.sv
// rtl/ex_div_sequencer_pkg.sv - shared types for the EX-stage divider sequencer
package ex_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/ex_div_sequencer_if.sv
// rtl/ex_div_sequencer_if.sv - EX-stage handshake bundle between pipeline control and divider
interface ex_div_sequencer_if import ex_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   dividend_i;
  logic [WIDTH-1:0]   divisor_i;
  logic               annul_i;
  logic               hold_i;
  logic               ok_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_zero_o;
  logic               busy_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i, hold_i,
    input  ok_o, result_o, div_zero_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i, hold_i,
    output ok_o, result_o, div_zero_o, busy_o
  );
endinterface

// File: rtl/ex_div_sequencer_div_step.sv
// rtl/ex_div_sequencer_div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             a_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH-1:0] shifted_low;

  // rem < b always holds, so when the trial subtraction succeeds the
  // difference fits in WIDTH bits even though {rem, a_msb} needs WIDTH+1.
  assign shifted_low = {rem[WIDTH-2:0], a_msb};
  assign q_bit       = ({rem, a_msb} >= {1'b0, b});
  assign rem_next    = q_bit ? (shifted_low - b) : shifted_low;
endmodule

// File: rtl/ex_div_sequencer.sv
// rtl/ex_div_sequencer.sv - multi-cycle signed/unsigned restoring divider controller for EX
// Optional: DIV_ZERO_FASTPATH_EN completes divide-by-zero in one cycle.
module ex_div_sequencer import ex_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ex_div_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state;
  logic [WIDTH-1:0]   a_q, b_q, rem_q, quo_q;
  logic [CW-1:0]      count_q;
  logic               q_neg, r_neg;
  logic [2*WIDTH-1:0] result_q;
  logic               div_zero_q;

  logic               dividend_neg, divisor_neg, divisor_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic               q_bit, last_iter;

  assign dividend_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign divisor_neg  = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign divisor_zero = (bus.divisor_i == '0);
  assign abs_a        = dividend_neg ? -bus.dividend_i : bus.dividend_i;
  assign abs_b        = divisor_neg  ? -bus.divisor_i  : bus.divisor_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .a_msb    (a_q[WIDTH-1]),
    .b        (b_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_next  = {quo_q[WIDTH-2:0], q_bit};
  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= DIV_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      count_q    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else if (bus.annul_i) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.start_i) begin
            a_q        <= abs_a;
            b_q        <= abs_b;
            q_neg      <= dividend_neg ^ divisor_neg;
            r_neg      <= dividend_neg;
            rem_q      <= '0;
            quo_q      <= '0;
            count_q    <= '0;
            div_zero_q <= divisor_zero;
`ifdef DIV_ZERO_FASTPATH_EN
            if (divisor_zero) begin
              result_q <= {bus.dividend_i, {WIDTH{1'b1}}};
              state    <= DIV_DONE;
            end else begin
              state    <= DIV_BUSY;
            end
`else
            state      <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          a_q     <= {a_q[WIDTH-2:0], 1'b0};
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            result_q <= {r_neg ? -rem_next : rem_next, q_neg ? -quo_next : quo_next};
            state    <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!bus.hold_i) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // ok drops in the accepting IDLE cycle so the pipeline stalls without a bubble.
  always_comb begin
    bus.ok_o = 1'b0;
    if (!rst_i)                 bus.ok_o = 1'b1;
    else if (state == DIV_IDLE) bus.ok_o = !(bus.start_i && !bus.annul_i);
    else if (state == DIV_DONE) bus.ok_o = 1'b1;
  end

  assign bus.result_o   = result_q;
  assign bus.div_zero_o = div_zero_q;
  assign bus.busy_o     = (state != DIV_IDLE);
endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb/tb_ex_div_sequencer.sv - self-checking bench for ex_div_sequencer
module tb_ex_div_sequencer;
  import ex_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_div_sequencer_if #(.WIDTH(DIV_WIDTH)) bus();

  ex_div_sequencer #(.WIDTH(DIV_WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic div_result_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_result_t r;
    longint sa, sb, q, m;
    if (b == 0) begin
      r.rem = a;
      r.quo = '1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      m  = sa % sb;
      r.quo = q[31:0];
      r.rem = m[31:0];
    end else begin
      r.quo = a / b;
      r.rem = a % b;
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
    if (b == 0) return 1;
`endif
    return 33;
  endfunction

  // Inputs are driven and outputs sampled just after the falling edge.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n, output logic [63:0] res, output logic dz,
                         output int lat);
    int cyc = 0;
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    #1;
    check("ok_cycle0", 64'(bus.ok_o), 64'(0));
    while (!bus.ok_o && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    lat = cyc;
    res = bus.result_o;
    dz  = bus.div_zero_o;
    if (hold_n > 0) begin
      bus.hold_i = 1'b1;
      for (int i = 0; i < hold_n; i++) begin
        @(negedge clk); #1;
        check("hold_result", bus.result_o, res);
        check("hold_ok_busy", {62'd0, bus.ok_o, bus.busy_o}, 64'd3);
      end
    end
    bus.start_i = 1'b0;
    bus.hold_i  = 1'b0;
    @(negedge clk); #1;
    check("idle_after_done", 64'(bus.busy_o), 64'(0));
  endtask

  logic [63:0] res, last_res;
  logic        dz;
  int          lat;
  div_result_t m;

  initial begin
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.annul_i = 1'b0; bus.hold_i = 1'b0;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0});

    // Reset state, including ok forced high while start is asserted.
    @(negedge clk);
    bus.start_i = 1'b1; #1;
    check("reset_ok", 64'(bus.ok_o), 64'(1));
    bus.start_i = 1'b0; #1;
    check("reset_busy", 64'(bus.busy_o), 64'(0));
    check("reset_result", bus.result_o, 64'd0);
    check("reset_dz", 64'(bus.div_zero_o), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_ok", 64'(bus.ok_o), 64'(1));

    foreach (vecs[i]) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, res, dz, lat);
      check($sformatf("vec%0d_result", i), res, {vecs[i].rem, vecs[i].quo});
      check($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_latency(vecs[i].b)));
      last_res = {vecs[i].rem, vecs[i].quo};
    end

    for (int i = 0; i < 40; i++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (sgn && b == 0) b = 32'd3;
      m = model(sgn, a, b);
      run_div(sgn, a, b, 0, res, dz, lat);
      check($sformatf("rnd%0d_result", i), res, {m.rem, m.quo});
      check($sformatf("rnd%0d_dz", i), 64'(dz), 64'(b == 0));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_latency(b)));
      last_res = {m.rem, m.quo};
    end

    // Annul during BUSY, then a fresh divide.
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
    end
    check("annul_pre_busy", {62'd0, bus.busy_o, bus.ok_o}, 64'd2);
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    @(negedge clk); #1;
    bus.annul_i = 1'b0; #1;
    check("annul_idle", {62'd0, bus.busy_o, bus.ok_o}, 64'd1);
    check("annul_result_kept", bus.result_o, last_res);
    run_div(1'b0, 32'd9, 32'd3, 0, res, dz, lat);
    check("post_annul_result", res, {32'd0, 32'd3});
    check("post_annul_latency", 64'(lat), 64'(33));

    // DONE held for 5 cycles with start still asserted.
    run_div(1'b0, 32'd100, 32'd7, 5, res, dz, lat);
    check("hold_final_result", res, {32'd2, 32'd14});

    // Asynchronous reset mid-BUSY.
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0; #1;
    check("rst_mid_busy", 64'(bus.busy_o), 64'(0));
    check("rst_mid_result", bus.result_o, 64'd0);
    check("rst_mid_ok", 64'(bus.ok_o), 64'(1));
    bus.start_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, res, dz, lat);
    check("post_rst_result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
